// File: rtl/axis_matmul_tile.sv
// AXI-Stream fixed-point tile: loads an N x M weight tile by column, then emits C-row = A-row x W with saturating Q-format math.
// Latency: input handshake in cycle t -> m_axis_tvalid in cycle t+M+1; one row every M+2 cycles at best.
// Backpressure: OUT holds tdata/tlast until m_axis_tready; both slave treadys stay low meanwhile.
module axis_matmul_tile #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int N        = 4,
    parameter int M        = 4,
    parameter int W_RELOAD = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic                 s_axis_w_tready,
    input  logic [N*WIDTH-1:0]   s_axis_w_tdata,
    input  logic                 s_axis_w_tvalid,
    input  logic                 s_axis_w_tlast,
    output logic                 s_axis_i_tready,
    input  logic [N*WIDTH-1:0]   s_axis_i_tdata,
    input  logic                 s_axis_i_tvalid,
    input  logic                 s_axis_i_tlast,
    input  logic                 m_axis_tready,
    output logic [M*WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 w_err
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    // Room for N full-width products without overflow before the shift.
    localparam int SW = 2*WIDTH + ((N > 1) ? $clog2(N) : 0);
    localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {LOAD_W, WAIT_I, MAC, OUT} state_t;

    state_t                         state_q, state_d;
    logic                           run_q;      // low during reset and its release cycle
    logic [CW-1:0]                  wcnt_q;
    logic [CW-1:0]                  col_q;
    logic [M-1:0][N*WIDTH-1:0]      w_q;        // w_q[c] = weight column c
    logic [N*WIDTH-1:0]             a_q;
    logic                           last_q;
    logic [M-1:0][WIDTH-1:0]        out_q;
    logic                           w_err_q;

    logic                           w_fire, i_fire, w_last_col;
    logic signed [SW-1:0]           acc, shifted;
    logic signed [WIDTH-1:0]        ae, we;
    logic signed [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]               sat;

    // Readies and valid decode registered state only, never an incoming tvalid.
    assign s_axis_w_tready = run_q && (state_q == LOAD_W);
    assign s_axis_i_tready = (state_q == WAIT_I);
    assign m_axis_tvalid   = (state_q == OUT);
    assign m_axis_tlast    = (state_q == OUT) && last_q;
    assign m_axis_tdata    = out_q;
    assign w_err           = w_err_q;

    assign w_fire     = s_axis_w_tvalid && s_axis_w_tready;
    assign i_fire     = s_axis_i_tvalid && s_axis_i_tready;
    assign w_last_col = (wcnt_q == CW'(M-1));

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= LOAD_W;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a weight frame ends on tlast or on the M-th column, whichever comes first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_W: if (w_fire && (s_axis_w_tlast || w_last_col)) state_d = WAIT_I;
            WAIT_I: if (i_fire) state_d = MAC;
            MAC:    if (col_q == CW'(M-1)) state_d = OUT;
            OUT:    if (m_axis_tready) state_d = (last_q && (W_RELOAD != 0)) ? LOAD_W : WAIT_I;
            default: state_d = LOAD_W;
        endcase
    end

    // Dot product of the latched row with column col_q, floor-shifted then clamped to WIDTH.
    always_comb begin
        acc  = '0;
        ae   = '0;
        we   = '0;
        prod = '0;
        for (int k = 0; k < N; k++) begin
            ae   = a_q[k*WIDTH +: WIDTH];
            we   = w_q[col_q][k*WIDTH +: WIDTH];
            prod = ae * we;
            acc  = acc + SW'(prod);
        end
        shifted = acc >>> FRAC;
        if (shifted > SMAX) begin
            sat = SMAX[WIDTH-1:0];
        end else if (shifted < SMIN) begin
            sat = SMIN[WIDTH-1:0];
        end else begin
            sat = shifted[WIDTH-1:0];
        end
    end

    // Datapath: weight capture with zero-fill on short frames, row latch, one output element per MAC cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q   <= 1'b0;
            wcnt_q  <= '0;
            col_q   <= '0;
            w_q     <= '0;
            a_q     <= '0;
            last_q  <= 1'b0;
            out_q   <= '0;
            w_err_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (w_fire) begin
                w_q[wcnt_q] <= s_axis_w_tdata;
                for (int c = 0; c < M; c++) begin
                    if (s_axis_w_tlast && (CW'(c) > wcnt_q)) w_q[c] <= '0;
                end
                wcnt_q <= (s_axis_w_tlast || w_last_col) ? '0 : wcnt_q + CW'(1);
                // Early tlast, or a full tile without tlast, both mean the frame length was wrong.
                if (s_axis_w_tlast != w_last_col) w_err_q <= 1'b1;
            end
            if (i_fire) begin
                a_q    <= s_axis_i_tdata;
                last_q <= s_axis_i_tlast;
                col_q  <= '0;
            end
            if (state_q == MAC) begin
                out_q[col_q] <= sat;
                col_q        <= (col_q == CW'(M-1)) ? '0 : col_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_matmul_tile.sv
// Bench for axis_matmul_tile: two instances (weight reload on / off) share all inputs.
// Expected rows come from a plain integer matrix-multiply model with floor division and clamping.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axis_matmul_tile;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int TMO   = 50;

    typedef int row_t [N];
    typedef int wmat_t [M][N];   // wmat_t[c][k]: column c, element k

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic [N*WIDTH-1:0] w_tdata = '0;
    logic               w_tvalid = 1'b0;
    logic               w_tlast  = 1'b0;
    logic [N*WIDTH-1:0] i_tdata = '0;
    logic               i_tvalid = 1'b0;
    logic               i_tlast  = 1'b0;
    logic               m_tready = 1'b1;

    logic               w_tready1, i_tready1, m_tvalid1, m_tlast1, w_err1;
    logic [M*WIDTH-1:0] m_tdata1;
    logic               w_tready0, i_tready0, m_tvalid0, m_tlast0, w_err0;
    logic [M*WIDTH-1:0] m_tdata0;

    int checks = 0;
    int errors = 0;

    axis_matmul_tile #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N), .M(M), .W_RELOAD(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_w_tready(w_tready1), .s_axis_w_tdata(w_tdata), .s_axis_w_tvalid(w_tvalid), .s_axis_w_tlast(w_tlast),
        .s_axis_i_tready(i_tready1), .s_axis_i_tdata(i_tdata), .s_axis_i_tvalid(i_tvalid), .s_axis_i_tlast(i_tlast),
        .m_axis_tready(m_tready), .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tlast(m_tlast1),
        .w_err(w_err1)
    );

    axis_matmul_tile #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N), .M(M), .W_RELOAD(0)) dut_keep (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_w_tready(w_tready0), .s_axis_w_tdata(w_tdata), .s_axis_w_tvalid(w_tvalid), .s_axis_w_tlast(w_tlast),
        .s_axis_i_tready(i_tready0), .s_axis_i_tdata(i_tdata), .s_axis_i_tvalid(i_tvalid), .s_axis_i_tlast(i_tlast),
        .m_axis_tready(m_tready), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
        .w_err(w_err0)
    );

    always #5 aclk = ~aclk;

    function automatic int rnd_elem(input int span);
        return int'($urandom_range(0, 2*span - 1)) - span;
    endfunction

    function automatic logic [N*WIDTH-1:0] pack_row(input row_t a);
        logic [N*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'(a[k]);
        return r;
    endfunction

    function automatic logic [N*WIDTH-1:0] pack_col(input wmat_t w, input int c);
        logic [N*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'(w[c][k]);
        return r;
    endfunction

    // C[j] = clamp(floor(sum_k A[k]*W[j][k] / 2^FRAC))
    function automatic logic [M*WIDTH-1:0] model_row(input row_t a, input wmat_t w);
        logic [M*WIDTH-1:0] r;
        longint scale, lim_hi, lim_lo;
        r      = '0;
        scale  = longint'(1) << FRAC;
        lim_hi = (longint'(1) << (WIDTH-1)) - 1;
        lim_lo = -(longint'(1) << (WIDTH-1));
        for (int j = 0; j < M; j++) begin
            longint s;
            longint q;
            s = 0;
            for (int k = 0; k < N; k++) s = s + longint'(a[k]) * longint'(w[j][k]);
            q = s / scale;
            if (s < 0 && q * scale != s) q = q - 1;
            if (q > lim_hi) q = lim_hi;
            if (q < lim_lo) q = lim_lo;
            r[j*WIDTH +: WIDTH] = WIDTH'(q);
        end
        return r;
    endfunction

    function automatic wmat_t rnd_w(input int span);
        wmat_t w;
        for (int c = 0; c < M; c++) for (int k = 0; k < N; k++) w[c][k] = rnd_elem(span);
        return w;
    endfunction

    function automatic wmat_t const_w(input int v);
        wmat_t w;
        for (int c = 0; c < M; c++) for (int k = 0; k < N; k++) w[c][k] = v;
        return w;
    endfunction

    function automatic row_t rnd_row(input int span);
        row_t a;
        for (int k = 0; k < N; k++) a[k] = rnd_elem(span);
        return a;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        w_tvalid = 1'b0; w_tlast = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; m_tready = 1'b1;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic send_w(input logic [N*WIDTH-1:0] d, input logic last);
        bit rdy;
        int n;
        n = 0;
        w_tdata = d; w_tlast = last; w_tvalid = 1'b1;
        do begin
            rdy = w_tready1;
            tick();
            n++;
        end while (!rdy && n < TMO);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL w_beat_timeout got tready=0 for %0d cycles exp 1", n);
        end
        w_tvalid = 1'b0; w_tlast = 1'b0;
    endtask

    task automatic load_w(input wmat_t w);
        for (int c = 0; c < M; c++) send_w(pack_col(w, c), c == M-1);
    endtask

    task automatic send_row(input row_t a, input logic last);
        bit rdy;
        int n;
        n = 0;
        i_tdata = pack_row(a); i_tlast = last; i_tvalid = 1'b1;
        do begin
            rdy = i_tready1;
            tick();
            n++;
        end while (!rdy && n < TMO);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL row_timeout got tready=0 for %0d cycles exp 1", n);
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    // Waits for the reload instance's tvalid, samples both instances, then consumes.
    task automatic get_out(output logic [M*WIDTH-1:0] d1, output logic l1,
                           output logic [M*WIDTH-1:0] d0, output logic l0, output int lat);
        lat = 0;
        while (!m_tvalid1 && lat < TMO) begin
            tick();
            lat++;
        end
        if (!m_tvalid1) begin
            checks++; errors++;
            $display("FAIL out_timeout got tvalid=0 for %0d cycles exp 1", lat);
        end
        d1 = m_tdata1; l1 = m_tlast1; d0 = m_tdata0; l0 = m_tlast0;
        m_tready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++; if (w_tready1 !== 1'b0) begin errors++; $display("FAIL rst_w_tready got %b exp 0", w_tready1); end
        checks++; if (i_tready1 !== 1'b0) begin errors++; $display("FAIL rst_i_tready got %b exp 0", i_tready1); end
        checks++; if (m_tvalid1 !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid1); end
        checks++; if (m_tlast1 !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", m_tlast1); end
        checks++; if (m_tdata1 !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_tdata1); end
        checks++; if (w_err1 !== 1'b0) begin errors++; $display("FAIL rst_w_err got %b exp 0", w_err1); end
        aresetn = 1'b1;
        tick();
        checks++; if (w_tready1 !== 1'b1) begin errors++; $display("FAIL rel_w_tready got %b exp 1", w_tready1); end
        checks++; if (i_tready1 !== 1'b0) begin errors++; $display("FAIL rel_i_tready got %b exp 0", i_tready1); end
    endtask

    task automatic test_identity();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        for (int c = 0; c < M; c++) for (int k = 0; k < N; k++) w[c][k] = (c == k) ? 256 : 0;
        load_w(w);
        checks++; if (i_tready1 !== 1'b1) begin errors++; $display("FAIL id_i_tready got %b exp 1", i_tready1); end
        checks++; if (w_err1 !== 1'b0) begin errors++; $display("FAIL id_w_err got %b exp 0", w_err1); end
        a = '{256, 512, 256, 512};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = {16'h0200, 16'h0100, 16'h0200, 16'h0100};
        // lat counts edges after the handshake cycle: M of them puts tvalid M+1 cycles after it.
        checks++; if (lat !== M) begin errors++; $display("FAIL id_latency got %0d exp %0d", lat, M); end
        checks++; if (d1 !== exp) begin errors++; $display("FAIL id_data got %h exp %h", d1, exp); end
        checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL id_tlast got %b exp 0", l1); end
    endtask

    task automatic test_ones();
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        load_w(const_w(256));
        a = '{256, 512, 256, 512};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = {M{16'h0600}};
        checks++; if (d1 !== exp) begin errors++; $display("FAIL ones_a got %h exp %h", d1, exp); end
        a = '{128, 128, 128, 128};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = {M{16'h0200}};
        checks++; if (d1 !== exp) begin errors++; $display("FAIL ones_b got %h exp %h", d1, exp); end
    endtask

    task automatic test_saturation();
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        load_w(const_w(32512));
        a = '{32512, 32512, 32512, 32512};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = {M{16'h7FFF}};
        checks++; if (d1 !== exp) begin errors++; $display("FAIL sat_pos got %h exp %h", d1, exp); end
        a = '{-32512, -32512, -32512, -32512};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = {M{16'h8000}};
        checks++; if (d1 !== exp) begin errors++; $display("FAIL sat_neg got %h exp %h", d1, exp); end
    endtask

    task automatic test_random();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        w = rnd_w(2048);
        load_w(w);
        for (int r = 0; r < 8; r++) begin
            a = rnd_row((r % 2 == 0) ? 1024 : 32768);
            send_row(a, r == 7);
            get_out(d1, l1, d0, l0, lat);
            exp = model_row(a, w);
            checks++; if (d1 !== exp) begin errors++; $display("FAIL rand_row%0d got %h exp %h", r, d1, exp); end
            checks++; if (l1 !== (r == 7)) begin errors++; $display("FAIL rand_tlast%0d got %b exp %b", r, l1, r == 7); end
        end
    endtask

    task automatic test_frame_reload();
        wmat_t w1, w2;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        w1 = rnd_w(1024);
        load_w(w1);
        for (int r = 0; r < 3; r++) begin
            a = rnd_row(1024);
            send_row(a, r == 2);
            get_out(d1, l1, d0, l0, lat);
            exp = model_row(a, w1);
            checks++; if (d1 !== exp) begin errors++; $display("FAIL frame_row%0d got %h exp %h", r, d1, exp); end
            checks++; if (l1 !== (r == 2)) begin errors++; $display("FAIL frame_tlast%0d got %b exp %b", r, l1, r == 2); end
            checks++; if (d0 !== exp) begin errors++; $display("FAIL keep_row%0d got %h exp %h", r, d0, exp); end
        end
        checks++; if (w_tready1 !== 1'b1) begin errors++; $display("FAIL reload_w_tready got %b exp 1", w_tready1); end
        checks++; if (i_tready1 !== 1'b0) begin errors++; $display("FAIL reload_i_tready got %b exp 0", i_tready1); end
        checks++; if (w_tready0 !== 1'b0) begin errors++; $display("FAIL keep_w_tready got %b exp 0", w_tready0); end
        checks++; if (i_tready0 !== 1'b1) begin errors++; $display("FAIL keep_i_tready got %b exp 1", i_tready0); end
        w2 = rnd_w(1024);
        for (int c = 0; c < M; c++) begin
            send_w(pack_col(w2, c), c == M-1);
            checks++;
            if (i_tready1 !== (c == M-1)) begin
                errors++; $display("FAIL reload_beat%0d_i_tready got %b exp %b", c, i_tready1, c == M-1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            a = rnd_row(1024);
            send_row(a, r == 1);
            get_out(d1, l1, d0, l0, lat);
            exp = model_row(a, w2);
            checks++; if (d1 !== exp) begin errors++; $display("FAIL frame2_row%0d got %h exp %h", r, d1, exp); end
            exp = model_row(a, w1);
            checks++; if (d0 !== exp) begin errors++; $display("FAIL keep2_row%0d got %h exp %h", r, d0, exp); end
            checks++; if (l0 !== (r == 1)) begin errors++; $display("FAIL keep2_tlast%0d got %b exp %b", r, l0, r == 1); end
        end
    endtask

    task automatic test_backpressure();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] exp;
        int n;
        apply_reset();
        w = rnd_w(1024);
        load_w(w);
        a = rnd_row(1024);
        exp = model_row(a, w);
        m_tready = 1'b0;
        send_row(a, 1'b1);
        n = 0;
        while (!m_tvalid1 && n < TMO) begin
            tick();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (m_tvalid1 !== 1'b1) begin errors++; $display("FAIL bp_tvalid%0d got %b exp 1", i, m_tvalid1); end
            checks++; if (m_tdata1 !== exp) begin errors++; $display("FAIL bp_tdata%0d got %h exp %h", i, m_tdata1, exp); end
            checks++; if (m_tlast1 !== 1'b1) begin errors++; $display("FAIL bp_tlast%0d got %b exp 1", i, m_tlast1); end
            checks++; if (i_tready1 !== 1'b0 || w_tready1 !== 1'b0) begin
                errors++; $display("FAIL bp_treadys%0d got i=%b w=%b exp 0 0", i, i_tready1, w_tready1);
            end
            tick();
        end
        m_tready = 1'b1;
        tick();
        checks++; if (m_tvalid1 !== 1'b0) begin errors++; $display("FAIL bp_release_tvalid got %b exp 0", m_tvalid1); end
        checks++; if (w_tready1 !== 1'b1) begin errors++; $display("FAIL bp_release_w_tready got %b exp 1", w_tready1); end
    endtask

    task automatic test_short_weights();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        w = rnd_w(1024);
        send_w(pack_col(w, 0), 1'b0);
        send_w(pack_col(w, 1), 1'b1);
        for (int c = 2; c < M; c++) for (int k = 0; k < N; k++) w[c][k] = 0;
        checks++; if (w_err1 !== 1'b1) begin errors++; $display("FAIL short_w_err got %b exp 1", w_err1); end
        checks++; if (w_tready1 !== 1'b0) begin errors++; $display("FAIL short_w_tready got %b exp 0", w_tready1); end
        checks++; if (i_tready1 !== 1'b1) begin errors++; $display("FAIL short_i_tready got %b exp 1", i_tready1); end
        a = rnd_row(1024);
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = model_row(a, w);
        checks++; if (d1 !== exp) begin errors++; $display("FAIL short_row got %h exp %h", d1, exp); end
        checks++; if (d1[2*WIDTH +: 2*WIDTH] !== '0) begin
            errors++; $display("FAIL short_zero_cols got %h exp 0", d1[2*WIDTH +: 2*WIDTH]);
        end
        checks++; if (w_err1 !== 1'b1) begin errors++; $display("FAIL short_w_err_sticky got %b exp 1", w_err1); end
    endtask

    task automatic test_long_weights();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0, exp;
        logic l1, l0;
        int lat;
        apply_reset();
        w = rnd_w(1024);
        for (int c = 0; c < M; c++) send_w(pack_col(w, c), 1'b0);
        checks++; if (w_err1 !== 1'b1) begin errors++; $display("FAIL long_w_err got %b exp 1", w_err1); end
        w_tdata = pack_col(w, 0); w_tvalid = 1'b1; w_tlast = 1'b1;
        tick();
        checks++; if (w_tready1 !== 1'b0) begin errors++; $display("FAIL long_surplus_tready got %b exp 0", w_tready1); end
        w_tvalid = 1'b0; w_tlast = 1'b0;
        a = rnd_row(1024);
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        exp = model_row(a, w);
        checks++; if (d1 !== exp) begin errors++; $display("FAIL long_row got %h exp %h", d1, exp); end
    endtask

    task automatic test_reset_mid_mac();
        wmat_t w;
        row_t a;
        logic [M*WIDTH-1:0] d1, d0;
        logic l1, l0;
        int lat;
        apply_reset();
        w = rnd_w(1024);
        load_w(w);
        a = '{256, 256, 256, 256};
        send_row(a, 1'b0);
        get_out(d1, l1, d0, l0, lat);
        a = rnd_row(1024);
        send_row(a, 1'b1);
        tick();
        aresetn = 1'b0;
        #1;
        checks++; if (m_tdata1 !== '0) begin errors++; $display("FAIL midrst_tdata got %h exp 0", m_tdata1); end
        checks++; if (m_tvalid1 !== 1'b0 || m_tlast1 !== 1'b0) begin
            errors++; $display("FAIL midrst_tvalid_tlast got %b %b exp 0 0", m_tvalid1, m_tlast1);
        end
        checks++; if (w_tready1 !== 1'b0 || i_tready1 !== 1'b0) begin
            errors++; $display("FAIL midrst_treadys got w=%b i=%b exp 0 0", w_tready1, i_tready1);
        end
        aresetn = 1'b1;
        tick();
        checks++; if (w_tready1 !== 1'b1) begin errors++; $display("FAIL midrst_release_w_tready got %b exp 1", w_tready1); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_saturation();
        test_random();
        test_frame_reload();
        test_backpressure();
        test_short_weights();
        test_long_weights();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_matmul_tile.md
Name: axis_matmul_tile

Overview:
- Parametrised AXI-Stream fixed-point matrix-multiply tile, the successor to the fixed-width axis_top.
- Loads an N x M weight tile column-by-column on s_axis_w, then streams rows of A (N elements per beat) on s_axis_i, and emits one row of C = A x W (M elements per beat) on m_axis.
- Adds generic N/M/width, saturating Q-format arithmetic, optional weight reuse across frames, and weight-frame error reporting.

Parameters:
- WIDTH, 16, signed element width (two's complement).
- FRAC, 8, fractional bits (Q8.8 default; 0x0100 = 1.0).
- N, 4, elements per input row / per weight column (inner dimension).
- M, 4, weight columns = elements per output row.
- W_RELOAD, 1, 1: weights reloaded after every input frame (i tlast); 0: weights retained until reset.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_w_tready  out  1  weight stream ready.
- s_axis_w_tdata  in  N*WIDTH  one weight column; element k at [k*WIDTH +: WIDTH].
- s_axis_w_tvalid  in  1  weight beat valid.
- s_axis_w_tlast  in  1  last weight column.
- s_axis_i_tready  out  1  input stream ready.
- s_axis_i_tdata  in  N*WIDTH  one row of A, element k at [k*WIDTH +: WIDTH].
- s_axis_i_tvalid  in  1  input beat valid.
- s_axis_i_tlast  in  1  last row of frame.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  M*WIDTH  one row of C, element j at [j*WIDTH +: WIDTH].
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  copy of tlast of the producing input row.
- w_err  out  1  sticky: weight frame length != M.

Behaviour:
- Reset (async assert, sync release): state=LOAD_W; all outputs 0; weight buffer, column counter, output register, w_err cleared. Reset mid-operation aborts everything; partially loaded weights are discarded.
- Handshakes are standard AXIS (transfer = valid & ready).
- Ready/valid are registered-state decodes only, with no combinational path from any tvalid to any tready.
- LOAD_W:
  - s_axis_w_tready=1, all others 0.
  - Beat c is stored into column c; wcnt increments.
  - If tlast arrives on c<M-1: columns c+1..M-1 are zeroed, w_err set, go to WAIT_I.
  - On c==M-1: go to WAIT_I; if tlast=0 on that beat, w_err is set and surplus weight beats are left unaccepted (tready=0) until the next LOAD_W.
- WAIT_I:
  - s_axis_i_tready=1.
  - On transfer, the row is latched into a_reg and tlast into last_reg; col=0; go to MAC.
- MAC (M cycles):
  - Each cycle computes the dot product of a_reg with column col.
  - Products are full 2*WIDTH signed; the sum is extended by ceil(log2 N) bits.
  - The sum is arithmetic-shifted right by FRAC (floor), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Result is written to out_reg[col]; col++. After col==M-1, go to OUT.
- OUT:
  - m_axis_tvalid=1, tdata=out_reg, tlast=last_reg; held stable until m_axis_tready.
  - On transfer: if last_reg && W_RELOAD, go to LOAD_W; else go to WAIT_I.
- Latency: input handshake at cycle t gives m_axis_tvalid high at t+M+1. Peak throughput is 1 row per M+2 cycles.
- Backpressure: while in OUT with tready=0, both s_*_tready stay 0 and no state changes.
- w_err clears only on reset.

Test Plan:
- N=M=4, identity W (diagonal 0x0100), row A=[0x0100,0x0200,0x0100,0x0200] -> output row identical, tvalid exactly 5 cycles after input handshake.
- All-ones W (every element 0x0100), A=[1.0,2.0,1.0,2.0] -> every output element 0x0600; A=[0x0080 x4] -> 0x0200.
- Saturation: W all 0x7F00, A all 0x7F00 -> all 0x7FFF; A all 0x8100 (-127.0) -> all 0x8000.
- Frame of 3 rows, i tlast on row 3, W_RELOAD=1 -> m_axis_tlast only on output 3; s_axis_w_tready rises the cycle after that transfer; s_axis_i_tready stays 0 until 4 new weight beats arrive.
- W_RELOAD=0, same frame then a second frame -> no reload; second frame uses the original weights.
- m_axis_tready low for 6 cycles during OUT -> tdata/tlast stable, s_axis_i_tready 0; transfer completes on release.
- Weight tlast on beat 2 -> columns 2,3 output 0x0000, w_err=1.
- Reset asserted during MAC -> outputs 0 immediately, s_axis_w_tready=1 after release.
